// File: rtl/fnd_scan_ctrl_pkg.sv
// Shared constants for the FND scan controller: segment patterns, select level, FSM states.
package fnd_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        S_BLANK = 2'd0,
        S_ON    = 2'd1,
        S_OFF   = 2'd2
    } state_t;

    // Common-node select is active-low
    localparam logic ENB_ACTIVE = 1'b0;

    // {a..g} patterns for 0-9, entry 10 is blank
    localparam logic [6:0] SEG_PAT [11] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
        7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B,
        7'h00
    };

    function automatic logic [31:0] calc_on_len(input logic [31:0] span,
                                                input logic [31:0] code,
                                                input int          shift);
        return (span * (code + 32'd1)) >> shift;
    endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// Display data / load handshake bundle between the pattern decoders, scan controller and pins.
interface fnd_scan_ctrl_if #(
    parameter int NUM_DIGIT = 6,
    parameter int BRIGHT_W  = 3
);
    logic [7*NUM_DIGIT-1:0] i_digit_seg;
    logic [NUM_DIGIT-1:0]   i_dp;
    logic [NUM_DIGIT-1:0]   i_digit_en;
    logic [BRIGHT_W-1:0]    i_bright;
    logic                   i_load;
    logic [NUM_DIGIT-1:0]   o_seg_enb;
    logic [6:0]             o_seg;
    logic                   o_seg_dp;
    logic                   o_frame_done;
    logic                   o_load_pend;

    modport master (
        output i_digit_seg, i_dp, i_digit_en, i_bright, i_load,
        input  o_seg_enb, o_seg, o_seg_dp, o_frame_done, o_load_pend
    );

    modport slave (
        input  i_digit_seg, i_dp, i_digit_en, i_bright, i_load,
        output o_seg_enb, o_seg, o_seg_dp, o_frame_done, o_load_pend
    );
endinterface

// File: rtl/fnd_slot_timer.sv
// Slot counter, digit index and per-slot brightness latch for the scan controller.
module fnd_slot_timer #(
    parameter int NUM_DIGIT = 6,
    parameter int SCAN_DIV  = 50000,
    parameter int BRIGHT_W  = 3,
    parameter int CNT_W     = 16,
    parameter int IDX_W     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BRIGHT_W-1:0] i_bright,
    output logic                slot_start,
    output logic                slot_end,
    output logic                frame_end,
    output logic [CNT_W-1:0]    cnt,
    output logic [IDX_W-1:0]    idx,
    output logic [BRIGHT_W-1:0] bright_q
);
    logic last_idx;

    always_comb begin
        slot_start = (cnt == '0);
        slot_end   = (cnt == CNT_W'(SCAN_DIV - 1));
        last_idx   = (idx == IDX_W'(NUM_DIGIT - 1));
        frame_end  = slot_end && last_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= '0;
            bright_q <= '0;
        end else begin
            if (slot_start) bright_q <= i_bright;
            if (slot_end) begin
                cnt <= '0;
                idx <= last_idx ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// N-digit multiplexed seven-segment scan controller with blanking, PWM dimming and frame-synchronous load.
module fnd_scan_ctrl
    import fnd_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGIT = 6,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter int BRIGHT_W  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    fnd_scan_ctrl_if.slave  bus
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGIT > 1) ? $clog2(NUM_DIGIT) : 1;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [BRIGHT_W-1:0] bright_q, bright_cur;
    logic                slot_start, slot_end, frame_end;

    fnd_slot_timer #(
        .NUM_DIGIT (NUM_DIGIT),
        .SCAN_DIV  (SCAN_DIV),
        .BRIGHT_W  (BRIGHT_W),
        .CNT_W     (CNT_W),
        .IDX_W     (IDX_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_bright   (bus.i_bright),
        .slot_start (slot_start),
        .slot_end   (slot_end),
        .frame_end  (frame_end),
        .cnt        (cnt),
        .idx        (idx),
        .bright_q   (bright_q)
    );

    logic [7*NUM_DIGIT-1:0] stage_seg, shadow_seg;
    logic [NUM_DIGIT-1:0]   stage_dp, shadow_dp, stage_en, shadow_en;
    logic                   pend_q;

    state_t               state_q, state_d;
    logic [31:0]          cnt_nxt, on_len;
    logic [NUM_DIGIT-1:0] enb_d, enb_q;
    logic [6:0]           seg_d, seg_q;
    logic                 dp_d, dp_q, fd_q;

    // state_q always describes the current cnt, so the decision looks one count ahead;
    // on the slot's first cycle the brightness being latched is used directly.
    always_comb begin
        bright_cur = slot_start ? bus.i_bright : bright_q;
        on_len     = calc_on_len(32'(SCAN_DIV - BLANK_CYC), 32'(bright_cur), BRIGHT_W);
        cnt_nxt    = slot_end ? '0 : 32'(cnt) + 32'd1;
        state_d    = S_OFF;
        if (cnt_nxt < 32'(BLANK_CYC))
            state_d = S_BLANK;
        else if (cnt_nxt < 32'(BLANK_CYC) + on_len)
            state_d = S_ON;

        enb_d = '1;
        seg_d = '0;
        dp_d  = 1'b0;
        if (state_q == S_ON && shadow_en[idx]) begin
            enb_d[idx] = ENB_ACTIVE;
            seg_d      = shadow_seg[32'(idx) * 32'd7 +: 7];
            dp_d       = shadow_dp[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_BLANK;
        else        state_q <= state_d;
    end

    // A load landing on the boundary bypasses staging so it shows in the very next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_seg  <= '0;
            stage_dp   <= '0;
            stage_en   <= '0;
            shadow_seg <= '0;
            shadow_dp  <= '0;
            shadow_en  <= '0;
            pend_q     <= 1'b0;
        end else begin
            if (bus.i_load) begin
                stage_seg <= bus.i_digit_seg;
                stage_dp  <= bus.i_dp;
                stage_en  <= bus.i_digit_en;
            end
            if (frame_end) begin
                if (bus.i_load) begin
                    shadow_seg <= bus.i_digit_seg;
                    shadow_dp  <= bus.i_dp;
                    shadow_en  <= bus.i_digit_en;
                end else if (pend_q) begin
                    shadow_seg <= stage_seg;
                    shadow_dp  <= stage_dp;
                    shadow_en  <= stage_en;
                end
                pend_q <= 1'b0;
            end else if (bus.i_load) begin
                pend_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enb_q <= '1;
            seg_q <= '0;
            dp_q  <= 1'b0;
            fd_q  <= 1'b0;
        end else begin
            enb_q <= enb_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
            fd_q  <= frame_end;
        end
    end

    assign bus.o_seg_enb    = enb_q;
    assign bus.o_seg        = seg_q;
    assign bus.o_seg_dp     = dp_q;
    assign bus.o_frame_done = fd_q;
    assign bus.o_load_pend  = pend_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: 4 digits, 16-cycle slots, 2 blank cycles, 2-bit brightness.
module tb_fnd_scan_ctrl;
    import fnd_scan_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fnd_scan_ctrl_if #(.NUM_DIGIT(4), .BRIGHT_W(2)) bus ();

    fnd_scan_ctrl #(
        .NUM_DIGIT (4),
        .SCAN_DIV  (16),
        .BLANK_CYC (2),
        .BRIGHT_W  (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [3:0] enb;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
        logic       pend;
    } exp_t;

    exp_t sb[$];

    // Time-based reference: position in frame from a free cycle count, data from load history
    int          mk = 0;
    int          q, p, d, onl, mb = 0;
    logic [3:0]  sel;
    exp_t        e;
    logic [27:0] m_seg = '0, s_seg = '0;
    logic [3:0]  m_dp = '0, m_en = '0, s_dp = '0, s_en = '0;
    logic        m_pend = 1'b0;

    always @(posedge clk) begin
        if (rst_n) begin
            q = mk;
            p = q % 16;
            d = (q / 16) % 4;
            if (p == 0) mb = int'(bus.i_bright);
            onl = (14 * (mb + 1)) >> 2;
            e = '{enb: 4'hF, seg: 7'h00, dp: 1'b0, fd: 1'b0, pend: 1'b0};
            if (p >= 2 && p < 2 + onl && m_en[d]) begin
                sel   = 4'b0001 << d;
                e.enb = ~sel;
                e.seg = m_seg[7*d +: 7];
                e.dp  = m_dp[d];
            end
            e.fd = (q % 64 == 63);
            if (bus.i_load) begin
                s_seg = bus.i_digit_seg;
                s_dp  = bus.i_dp;
                s_en  = bus.i_digit_en;
            end
            if (q % 64 == 63) begin
                if (bus.i_load || m_pend) begin
                    m_seg = s_seg;
                    m_dp  = s_dp;
                    m_en  = s_en;
                end
                m_pend = 1'b0;
            end else if (bus.i_load) begin
                m_pend = 1'b1;
            end
            e.pend = m_pend;
            sb.push_back(e);
            mk++;
        end
    end

    always @(negedge rst_n) begin
        sb.delete();
        mk = 0; mb = 0; m_pend = 1'b0;
        m_seg = '0; m_dp = '0; m_en = '0;
        s_seg = '0; s_dp = '0; s_en = '0;
    end

    always @(negedge clk) begin
        exp_t got, want;
        if (rst_n && sb.size() != 0) begin
            want = sb.pop_front();
            got  = '{enb: bus.o_seg_enb, seg: bus.o_seg, dp: bus.o_seg_dp,
                     fd: bus.o_frame_done, pend: bus.o_load_pend};
            check("scoreboard", 32'(got), 32'(want));
        end
    end

    function automatic exp_t outs();
        return '{enb: bus.o_seg_enb, seg: bus.o_seg, dp: bus.o_seg_dp,
                 fd: bus.o_frame_done, pend: bus.o_load_pend};
    endfunction

    task automatic wait_fd(output int n);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (bus.o_frame_done) return;
        end
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mk % 64 == target) break;
        end
        check("reach_position", 32'(mk % 64), 32'(target));
    endtask

    task automatic scramble();
        bus.i_digit_seg = 28'($urandom);
        bus.i_dp        = 4'($urandom);
        bus.i_digit_en  = 4'($urandom);
    endtask

    typedef struct packed {
        logic [27:0]      seg;
        logic [3:0]       dp;
        logic [3:0]       en;
        logic [1:0]       bright;
        logic [3:0][7:0]  exp_on;
    } vec_t;

    function automatic vec_t mk_vec(input logic [27:0] seg, input logic [3:0] dp, input logic [3:0] en,
                                    input logic [1:0] br, input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.seg = seg; v.dp = dp; v.en = en; v.bright = br;
        v.exp_on[0] = 8'(e0); v.exp_on[1] = 8'(e1); v.exp_on[2] = 8'(e2); v.exp_on[3] = 8'(e3);
        return v;
    endfunction

    initial begin
        vec_t       vecs [5];
        logic [27:0] base, alt;
        int         n, bad, cnt;
        int         on [4];
        logic [3:0] s4;
        exp_t       r;

        base = {SEG_PAT[3], SEG_PAT[2], SEG_PAT[1], SEG_PAT[0]};
        alt  = {SEG_PAT[9], SEG_PAT[8], SEG_PAT[6], SEG_PAT[5]};
        vecs[0] = mk_vec(base, 4'b0000, 4'b1111, 2'd3, 14, 14, 14, 14);
        vecs[1] = mk_vec(base, 4'b0000, 4'b1111, 2'd0,  3,  3,  3,  3);
        vecs[2] = mk_vec(base, 4'b0000, 4'b1111, 2'd1,  7,  7,  7,  7);
        vecs[3] = mk_vec(base, 4'b0000, 4'b1011, 2'd3, 14, 14,  0, 14);
        vecs[4] = mk_vec(alt,  4'b0101, 4'b0001, 2'd2, 10,  0,  0,  0);

        bus.i_digit_seg = '0; bus.i_dp = '0; bus.i_digit_en = '0;
        bus.i_bright = '0; bus.i_load = 1'b0;

        repeat (3) @(negedge clk);
        r = outs();
        check("reset_state", 32'(r), 32'({4'hF, 7'h00, 1'b0, 1'b0, 1'b0}));
        rst_n = 1'b1;
        wait_fd(n);
        check("first_frame_done", 32'(n), 32'd64);
        wait_fd(n);
        check("frame_period", 32'(n), 32'd64);

        for (int i = 0; i < 5; i++) begin
            wait_pos(21);
            bus.i_digit_seg = vecs[i].seg;
            bus.i_dp        = vecs[i].dp;
            bus.i_digit_en  = vecs[i].en;
            bus.i_bright    = vecs[i].bright;
            bus.i_load      = 1'b1;
            @(negedge clk);
            bus.i_load = 1'b0;
            check($sformatf("vec%0d_pend_set", i), 32'(bus.o_load_pend), 32'd1);
            scramble();
            wait_fd(n);
            check($sformatf("vec%0d_frame_wait", i), 32'(n <= 64), 32'd1);
            check($sformatf("vec%0d_pend_clr", i), 32'(bus.o_load_pend), 32'd0);
            bad = 0;
            for (int k = 0; k < 4; k++) on[k] = 0;
            for (int s = 0; s < 64; s++) begin
                @(negedge clk);
                if (bus.o_seg_enb == 4'hF) begin
                    if (bus.o_seg != 7'h00 || bus.o_seg_dp != 1'b0) bad++;
                end else begin
                    cnt = 0;
                    for (int k = 0; k < 4; k++) begin
                        s4 = 4'b0001 << k;
                        if (bus.o_seg_enb == ~s4 && bus.o_seg == vecs[i].seg[7*k +: 7]
                            && bus.o_seg_dp == vecs[i].dp[k]) begin
                            on[k]++;
                            cnt = 1;
                        end
                    end
                    if (cnt == 0) bad++;
                end
            end
            for (int k = 0; k < 4; k++)
                check($sformatf("vec%0d_digit%0d_on", i, k), 32'(on[k]), 32'(vecs[i].exp_on[k]));
            check($sformatf("vec%0d_bad_cycles", i), 32'(bad), 32'd0);
        end

        // Load coinciding with the frame boundary
        wait_pos(63);
        bus.i_digit_seg = {SEG_PAT[7], SEG_PAT[4], SEG_PAT[1], SEG_PAT[9]};
        bus.i_dp        = 4'b1000;
        bus.i_digit_en  = 4'b1111;
        bus.i_bright    = 2'd3;
        bus.i_load      = 1'b1;
        @(negedge clk);
        bus.i_load = 1'b0;
        check("bypass_pend", 32'(bus.o_load_pend), 32'd0);
        check("bypass_frame_done", 32'(bus.o_frame_done), 32'd1);
        scramble();
        cnt = 0;
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            if (bus.o_seg_enb == 4'b1110 && bus.o_seg == SEG_PAT[9]) cnt++;
        end
        check("bypass_slot0_on", 32'(cnt), 32'd14);

        // Brightness change mid-slot waits for the next slot
        wait_pos(37);
        bus.i_bright = 2'd0;
        cnt = 0;
        for (int s = 0; s < 11; s++) begin
            @(negedge clk);
            if (bus.o_seg_enb != 4'hF) cnt++;
        end
        check("bright_hold_in_slot", 32'(cnt), 32'd11);
        cnt = 0;
        for (int s = 0; s < 16; s++) begin
            @(negedge clk);
            if (bus.o_seg_enb != 4'hF) cnt++;
        end
        check("bright_next_slot", 32'(cnt), 32'd3);
        bus.i_bright = 2'd3;

        // Asynchronous reset in the middle of slot 2's lit window
        wait_pos(40);
        check("pre_reset_on", 32'(bus.o_seg_enb), 32'(4'b1011));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        r = outs();
        check("async_reset", 32'(r), 32'({4'hF, 7'h00, 1'b0, 1'b0, 1'b0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (bus.o_seg_enb != 4'hF || bus.o_seg != 7'h00) cnt++;
            if (bus.o_frame_done) break;
        end
        check("post_reset_frame_done", 32'(n), 32'd64);
        check("post_reset_dark", 32'(cnt), 32'd0);
        check("post_reset_pend", 32'(bus.o_load_pend), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
